track_select: RTL and testbench

- Parametrised track/selection register for the MP3 player front panel.
- Debounces PREV/NEXT step requests with a lockout counter and wraps the selected index modulo an arbitrary track count, not just a power of two.
- Adds play modes (sequential, repeat-one, shuffle, stop-at-end) and auto-advance on a track-end pulse from the decoder.
- Sits between the button/switch conditioner and the SD/file-fetch controller; drives the current track index.

---
 rtl/track_select.sv | 144 ++++++++++++++
 tb/tb_track_select.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/track_select.sv
// Track selection register: debounced PREV/NEXT stepping modulo NUM_TRACKS, play modes and auto-advance.
// Optional macro TRACK_SELECT_RELEASE_GATE_EN: a held button steps once until both buttons are released.
module track_select #(
  parameter int          NUM_TRACKS = 8,
  parameter int          SEL_W      = 3,
  parameter int          STEP_W     = 3,
  parameter int          LOCK_CYC   = 500000,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [STEP_W-1:0] PREV,
  input  logic [STEP_W-1:0] NEXT,
  input  logic              TRACK_END,
  input  logic [1:0]        MODE,
  output logic [SEL_W-1:0]  SEL,
  output logic              CHANGED,
  output logic              BUSY,
  output logic              STOPPED
);

  localparam int             CNT_W     = $clog2(LOCK_CYC + 1);
  localparam logic [SEL_W:0] NT        = (SEL_W + 1)'(NUM_TRACKS);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCK_CYC);

  typedef enum logic {IDLE, LOCK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [SEL_W-1:0] sel, sel_nxt;
  logic             changed, changed_nxt;
  logic             stopped, stopped_nxt;
  logic [15:0]      lfsr, lfsr_nxt;
  logic             accept;
  logic [SEL_W:0]   cur, s_prev, s_next, rnd, wide_nxt;
`ifdef TRACK_SELECT_RELEASE_GATE_EN
  logic             armed, armed_nxt;
`endif

  function automatic logic [SEL_W:0] step_mod(input logic [STEP_W-1:0] step);
    return (SEL_W + 1)'(32'(step) % 32'(NUM_TRACKS));
  endfunction

  // Operands are always below NUM_TRACKS, so one conditional subtract completes the wrap.
  function automatic logic [SEL_W:0] wrap(input logic [SEL_W:0] v);
    return (v >= NT) ? v - NT : v;
  endfunction

  always_comb begin
    cur         = {1'b0, sel};
    s_prev      = step_mod(PREV);
    s_next      = step_mod(NEXT);
    rnd         = (SEL_W + 1)'(32'(lfsr) % 32'(NUM_TRACKS));
    lfsr_nxt    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    state_nxt   = state;
    cnt_nxt     = cnt;
    wide_nxt    = cur;
    changed_nxt = 1'b0;
    stopped_nxt = stopped;
`ifdef TRACK_SELECT_RELEASE_GATE_EN
    accept      = (state == IDLE) && ((PREV != '0) || (NEXT != '0)) && armed;
    armed_nxt   = armed;
    if ((PREV == '0) && (NEXT == '0))
      armed_nxt = 1'b1;
    else if (accept)
      armed_nxt = 1'b0;
`else
    accept      = (state == IDLE) && ((PREV != '0) || (NEXT != '0));
`endif

    case (state)
      IDLE: if (accept) begin
        state_nxt = LOCK;
        cnt_nxt   = LOCK_LOAD;
      end
      LOCK: begin
        cnt_nxt = cnt - 1'b1;
        if (cnt == CNT_W'(1))
          state_nxt = IDLE;
      end
    endcase

    // A button wins over a simultaneous track end; the track end is simply dropped.
    if (accept) begin
      changed_nxt = 1'b1;
      stopped_nxt = 1'b0;
      if (PREV != '0)
        wide_nxt = wrap(cur + (NT - s_prev));
      else
        wide_nxt = wrap(cur + s_next);
    end else if (TRACK_END) begin
      case (MODE)
        2'd0: begin
          wide_nxt    = wrap(cur + 1'b1);
          changed_nxt = 1'b1;
        end
        2'd1: changed_nxt = 1'b1;
        2'd2: begin
          wide_nxt    = (rnd == cur) ? wrap(rnd + 1'b1) : rnd;
          changed_nxt = 1'b1;
        end
        default: begin
          if (cur < NT - 1'b1) begin
            wide_nxt    = cur + 1'b1;
            changed_nxt = 1'b1;
          end else begin
            stopped_nxt = 1'b1;
          end
        end
      endcase
    end
    sel_nxt = SEL_W'(wide_nxt);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      sel     <= '0;
      changed <= 1'b0;
      stopped <= 1'b0;
      lfsr    <= LFSR_SEED;
`ifdef TRACK_SELECT_RELEASE_GATE_EN
      armed   <= 1'b1;
`endif
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      sel     <= sel_nxt;
      changed <= changed_nxt;
      stopped <= stopped_nxt;
      lfsr    <= lfsr_nxt;
`ifdef TRACK_SELECT_RELEASE_GATE_EN
      armed   <= armed_nxt;
`endif
    end
  end

  assign SEL     = sel;
  assign CHANGED = changed;
  assign BUSY    = (state == LOCK);
  assign STOPPED = stopped;

endmodule

// File: tb/tb_track_select.sv
// Bench for track_select (5 tracks, 4-cycle lockout): a reference model pushes expected outputs
// to a scoreboard each cycle; directed checks cover wrap, priority, play modes, shuffle and reset.
module tb_track_select;

  localparam int          NT   = 5;
  localparam int          LC   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic       CLK = 1'b0;
  logic       RST;
  logic [2:0] PREV, NEXT;
  logic       TRACK_END;
  logic [1:0] MODE;
  logic [2:0] SEL;
  logic       CHANGED, BUSY, STOPPED;

  typedef struct packed {
    logic [2:0] sel;
    logic       changed;
    logic       busy;
    logic       stopped;
  } exp_t;

  exp_t        q[$];
  string       tq[$];
  int          total = 0;
  int          bad = 0;
  int          m_sel, m_cnt;
  bit          m_changed, m_stopped, m_armed;
  logic [15:0] m_lfsr;

  track_select #(
    .NUM_TRACKS(NT), .SEL_W(3), .STEP_W(3), .LOCK_CYC(LC), .LFSR_SEED(SEED)
  ) dut (
    .CLK(CLK), .RST(RST), .PREV(PREV), .NEXT(NEXT), .TRACK_END(TRACK_END),
    .MODE(MODE), .SEL(SEL), .CHANGED(CHANGED), .BUSY(BUSY), .STOPPED(STOPPED)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("[TB] FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // Reference behaviour for one clock edge, given the inputs sampled at that edge.
  task automatic modelStep(input int p, input int n, input int te, input int md, input int r);
    int          rr;
    bit          acc;
    logic [15:0] cur_lfsr;
    if (r != 0) begin
      m_sel = 0; m_cnt = 0; m_changed = 0; m_stopped = 0; m_lfsr = SEED; m_armed = 1;
      return;
    end
    cur_lfsr  = m_lfsr;
    m_lfsr    = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    m_changed = 0;
    acc = (m_cnt == 0) && ((p != 0) || (n != 0));
`ifdef TRACK_SELECT_RELEASE_GATE_EN
    acc = acc && m_armed;
`endif
    if (acc) begin
      if (p != 0) m_sel = (m_sel + NT - (p % NT)) % NT;
      else        m_sel = (m_sel + (n % NT)) % NT;
      m_changed = 1; m_stopped = 0; m_cnt = LC;
    end else begin
      if (m_cnt != 0) m_cnt--;
      if (te != 0) begin
        case (md)
          0: begin m_sel = (m_sel + 1) % NT; m_changed = 1; end
          1: m_changed = 1;
          2: begin
            rr = int'(cur_lfsr) % NT;
            if (rr == m_sel) rr = (rr + 1) % NT;
            m_sel = rr; m_changed = 1;
          end
          default: begin
            if (m_sel < NT - 1) begin m_sel++; m_changed = 1; end
            else m_stopped = 1;
          end
        endcase
      end
    end
`ifdef TRACK_SELECT_RELEASE_GATE_EN
    if ((p == 0) && (n == 0)) m_armed = 1;
    else if (acc) m_armed = 0;
`endif
  endtask

  task automatic checkOutput();
    exp_t  e;
    string t;
    e = q.pop_front();
    t = tq.pop_front();
    cmp({t, "/sel"}, 32'(SEL), 32'(e.sel));
    cmp({t, "/changed"}, 32'(CHANGED), 32'(e.changed));
    cmp({t, "/busy"}, 32'(BUSY), 32'(e.busy));
    cmp({t, "/stopped"}, 32'(STOPPED), 32'(e.stopped));
  endtask

  task automatic applyStimulus(input int p, input int n, input int te, input int md,
                               input int r, input string tag);
    exp_t e;
    PREV = 3'(p); NEXT = 3'(n); TRACK_END = 1'(te); MODE = 2'(md); RST = 1'(r);
    modelStep(p, n, te, md, r);
    e.sel = 3'(m_sel); e.changed = m_changed; e.busy = (m_cnt != 0); e.stopped = m_stopped;
    q.push_back(e);
    tq.push_back(tag);
    @(posedge CLK);
    #1;
    checkOutput();
  endtask

  task automatic idle(input int k, input int md);
    for (int i = 0; i < k; i++) applyStimulus(0, 0, 0, md, 0, "idle");
  endtask

  task automatic press(input int p, input int n, input int md, input string tag);
    applyStimulus(p, n, 0, md, 0, tag);
    idle(LC, md);
  endtask

  initial begin
    int       last, chg_count;
    bit [4:0] seen;
    PREV = '0; NEXT = '0; TRACK_END = 1'b0; MODE = '0; RST = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, "rst");
    applyStimulus(0, 0, 0, 0, 1, "rst");
    cmp("rst_sel", 32'(SEL), 0);
    cmp("rst_busy", 32'(BUSY), 0);

    applyStimulus(0, 1, 0, 0, 0, "next1");
    cmp("next1_sel", 32'(SEL), 1);
    cmp("next1_busy", 32'(BUSY), 1);
    applyStimulus(0, 0, 0, 0, 0, "lock1");
    applyStimulus(0, 1, 0, 0, 0, "next_in_busy");
    idle(2, 0);
    cmp("busy_ignored_sel", 32'(SEL), 1);
    cmp("lock_over", 32'(BUSY), 0);

    press(0, 3, 0, "next3");
    cmp("next3_sel", 32'(SEL), 4);
    press(0, 1, 0, "wrap_next");
    cmp("wrap_next_sel", 32'(SEL), 0);
    press(3, 0, 0, "wrap_prev");
    cmp("wrap_prev_sel", 32'(SEL), 2);
    press(1, 1, 0, "prev_wins");
    cmp("prev_wins_sel", 32'(SEL), 1);
    press(0, 7, 0, "next7");
    cmp("next7_sel", 32'(SEL), 3);
    press(2, 0, 0, "prev2");

    applyStimulus(0, 1, 1, 0, 0, "next_te");
    cmp("te_dropped_sel", 32'(SEL), 2);
    applyStimulus(0, 0, 1, 0, 0, "te_busy");
    cmp("te_busy_sel", 32'(SEL), 3);
    idle(3, 0);
    cmp("te_busy_end", 32'(BUSY), 0);

    applyStimulus(0, 0, 1, 1, 0, "repeat1");
    cmp("repeat1_sel", 32'(SEL), 3);
    cmp("repeat1_chg", 32'(CHANGED), 1);
    idle(1, 1);

    applyStimulus(0, 0, 1, 3, 0, "stop_adv");
    idle(1, 3);
    applyStimulus(0, 0, 1, 3, 0, "stop_end");
    cmp("stop_end_sel", 32'(SEL), 4);
    cmp("stop_end_flag", 32'(STOPPED), 1);
    cmp("stop_end_chg", 32'(CHANGED), 0);
    idle(1, 3);
    press(0, 1, 3, "stop_clear");
    cmp("stop_clear_sel", 32'(SEL), 0);
    cmp("stop_clear_flag", 32'(STOPPED), 0);

    // Shuffle with irregular spacing so the LFSR is sampled at varied phases.
    last = int'(SEL);
    seen = '0;
    for (int i = 0; i < 200; i++) begin
      applyStimulus(0, 0, 1, 2, 0, "shuffle");
      cmp("shuf_norepeat", 32'(int'(SEL) != last), 1);
      cmp("shuf_range", 32'(SEL < 3'd5), 1);
      seen[SEL] = 1'b1;
      last = int'(SEL);
      idle(int'($urandom_range(0, 2)), 2);
    end
    cmp("shuf_all_seen", 32'(seen), 32'h1f);

    applyStimulus(0, 1, 0, 0, 0, "pre_rst");
    idle(2, 0);
    applyStimulus(0, 0, 0, 0, 1, "rst_mid");
    cmp("rst_mid_sel", 32'(SEL), 0);
    cmp("rst_mid_busy", 32'(BUSY), 0);
    cmp("rst_mid_chg", 32'(CHANGED), 0);
    idle(1, 0);

    chg_count = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(0, 1, 0, 0, 0, "held");
      if (CHANGED) chg_count++;
    end
`ifdef TRACK_SELECT_RELEASE_GATE_EN
    cmp("held_steps", 32'(chg_count), 1);
`else
    cmp("held_steps", 32'(chg_count), 4);
`endif
    idle(5, 0);
    applyStimulus(0, 1, 0, 0, 0, "repress");
    cmp("repress_chg", 32'(CHANGED), 1);
    idle(LC, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
